// File: rtl/game_sequencer.sv
// Control FSM for the whack-a-mole datapath: start/guess strobes, result timeout, high score.
// Optional lockout after a wrong guess is built when WHACK_PENALTY_EN is defined.
module game_sequencer #(
  parameter int unsigned RESULT_TIMEOUT = 16,
  parameter int unsigned PENALTY_CYCLES = 50000000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] btn_i,
  input  logic       start_i,
  input  logic       guess_correct_i,
  input  logic       guess_wrong_i,
  input  logic       game_over_i,
  input  logic [7:0] score_i,
  output logic       restart_game_o,
  output logic [2:0] user_guess_o,
  output logic       eval_now_o,
  output logic [2:0] state_o,
  output logic       timeout_o,
  output logic [7:0] high_score_o
);

  localparam int unsigned TimeoutW = $clog2(RESULT_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StStart   = 3'd1,
    StReady   = 3'd2,
    StWait    = 3'd3,
    StOver    = 3'd4,
    StPenalty = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          btn_q;
  logic                start_q;
  logic [2:0]          guess_q, guess_d;
  logic                eval_q, eval_d;
  logic                timeout_q, timeout_d;
  logic [TimeoutW-1:0] cnt_q, cnt_d;
  logic [7:0]          hs_q, hs_d;
  logic [7:0]          btn_press;
  logic                start_press;
  logic [2:0]          low_idx;

`ifdef WHACK_PENALTY_EN
  logic [25:0] pen_q, pen_d;
`else
  logic unused_pen;
  assign unused_pen = ^PENALTY_CYCLES;
`endif

  assign btn_press   = btn_i & ~btn_q;
  assign start_press = start_i & ~start_q;

  // Scan from the top so the lowest pressed index is the one left standing.
  always_comb begin
    low_idx = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (btn_press[k]) low_idx = 3'(k);
    end
  end

  always_comb begin
    state_d   = state_q;
    guess_d   = guess_q;
    eval_d    = 1'b0;
    timeout_d = 1'b0;
    cnt_d     = '0;
    hs_d      = hs_q;
`ifdef WHACK_PENALTY_EN
    pen_d     = '0;
`endif
    case (state_q)
      StIdle, StOver: begin
        if (start_press) state_d = StStart;
      end
      StStart: state_d = StReady;
      StReady, StWait, StPenalty: begin
        if (start_press) begin
          state_d = StStart;
        end else if (game_over_i) begin
          state_d = StOver;
          if (score_i > hs_q) hs_d = score_i;
        end else if (state_q == StReady) begin
          if (|btn_press) begin
            state_d = StWait;
            eval_d  = 1'b1;
            guess_d = low_idx;
          end
        end else if (state_q == StWait) begin
          if (guess_correct_i) begin
            state_d = StReady;
          end else if (guess_wrong_i) begin
`ifdef WHACK_PENALTY_EN
            state_d = StPenalty;
`else
            state_d = StReady;
`endif
          end else if (32'(cnt_q) + 32'd1 >= RESULT_TIMEOUT) begin
            state_d   = StReady;
            timeout_d = 1'b1;
          end else begin
            cnt_d = (cnt_q == TimeoutW'(RESULT_TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
          end
        end else begin
`ifdef WHACK_PENALTY_EN
          if (32'(pen_q) + 32'd1 >= PENALTY_CYCLES) state_d = StReady;
          else pen_d = pen_q + 26'd1;
`else
          state_d = StReady;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      btn_q     <= '0;
      start_q   <= 1'b0;
      guess_q   <= '0;
      eval_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      hs_q      <= '0;
`ifdef WHACK_PENALTY_EN
      pen_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      btn_q     <= btn_i;
      start_q   <= start_i;
      guess_q   <= guess_d;
      eval_q    <= eval_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      hs_q      <= hs_d;
`ifdef WHACK_PENALTY_EN
      pen_q     <= pen_d;
`endif
    end
  end

  assign restart_game_o = (state_q == StStart);
  assign user_guess_o   = guess_q;
  assign eval_now_o     = eval_q;
  assign state_o        = state_q;
  assign timeout_o      = timeout_q;
  assign high_score_o   = hs_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed scenarios plus randomized run against a cycle model.
module tb_game_sequencer;

  localparam int unsigned ResTo = 16;
  localparam int unsigned PenCy = 4;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] btn_i = '0;
  logic       start_i = 1'b0;
  logic       guess_correct_i = 1'b0;
  logic       guess_wrong_i = 1'b0;
  logic       game_over_i = 1'b0;
  logic [7:0] score_i = '0;
  logic       restart_game_o;
  logic [2:0] user_guess_o;
  logic       eval_now_o;
  logic [2:0] state_o;
  logic       timeout_o;
  logic [7:0] high_score_o;

  int checks = 0;
  int errors = 0;

  game_sequencer #(
    .RESULT_TIMEOUT(ResTo),
    .PENALTY_CYCLES(PenCy)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .btn_i          (btn_i),
    .start_i        (start_i),
    .guess_correct_i(guess_correct_i),
    .guess_wrong_i  (guess_wrong_i),
    .game_over_i    (game_over_i),
    .score_i        (score_i),
    .restart_game_o (restart_game_o),
    .user_guess_o   (user_guess_o),
    .eval_now_o     (eval_now_o),
    .state_o        (state_o),
    .timeout_o      (timeout_o),
    .high_score_o   (high_score_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step();
    step();
    checks++;
    if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_o); end
    checks++;
    if ({restart_game_o, eval_now_o, timeout_o, user_guess_o, high_score_o} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs got r%0d e%0d t%0d g%0d h%0d want all 0",
               restart_game_o, eval_now_o, timeout_o, user_guess_o, high_score_o);
    end
    rst_i = 1'b0;
    step();
    checks++;
    if (state_o !== 3'd0) begin errors++; $display("FAIL idle_hold got %0d want 0", state_o); end
  endtask

  task automatic test_start();
    start_i = 1'b1;
    step();
    checks++;
    if (state_o !== 3'd1 || restart_game_o !== 1'b1) begin
      errors++; $display("FAIL start_cycle got s%0d r%0d want s1 r1", state_o, restart_game_o);
    end
    step();
    checks++;
    if (state_o !== 3'd2 || restart_game_o !== 1'b0) begin
      errors++; $display("FAIL start_ready got s%0d r%0d want s2 r0", state_o, restart_game_o);
    end
    start_i = 1'b0;
    step();
  endtask

  task automatic test_guess();
    btn_i = 8'b0000_0100;
    step();
    checks++;
    if (state_o !== 3'd3 || eval_now_o !== 1'b1 || user_guess_o !== 3'd2) begin
      errors++;
      $display("FAIL guess_eval got s%0d e%0d g%0d want s3 e1 g2", state_o, eval_now_o, user_guess_o);
    end
    btn_i = 8'h00;
    step();
    checks++;
    if (eval_now_o !== 1'b0 || state_o !== 3'd3) begin
      errors++; $display("FAIL guess_eval_once got s%0d e%0d want s3 e0", state_o, eval_now_o);
    end
    guess_correct_i = 1'b1;
    step();
    guess_correct_i = 1'b0;
    checks++;
    if (state_o !== 3'd2 || user_guess_o !== 3'd2) begin
      errors++; $display("FAIL guess_correct got s%0d g%0d want s2 g2", state_o, user_guess_o);
    end
  endtask

  task automatic test_multi_hold();
    int evals;
    btn_i = 8'b1010_0000;
    step();
    checks++;
    if (user_guess_o !== 3'd5 || eval_now_o !== 1'b1) begin
      errors++; $display("FAIL multi_lowest got g%0d e%0d want g5 e1", user_guess_o, eval_now_o);
    end
    guess_correct_i = 1'b1;
    step();
    guess_correct_i = 1'b0;
    evals = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (eval_now_o === 1'b1) evals++;
    end
    checks++;
    if (evals !== 0 || state_o !== 3'd2) begin
      errors++; $display("FAIL hold_no_retrigger got evals%0d s%0d want evals0 s2", evals, state_o);
    end
    btn_i = 8'h00;
    step();
  endtask

  task automatic test_timeout();
    int bad;
    btn_i = 8'h01;
    step();
    btn_i = 8'h00;
    checks++;
    if (state_o !== 3'd3 || user_guess_o !== 3'd0) begin
      errors++; $display("FAIL to_enter got s%0d g%0d want s3 g0", state_o, user_guess_o);
    end
    bad = 0;
    for (int j = 0; j < 15; j++) begin
      if (j == 5) btn_i = 8'h08;
      if (j == 7) btn_i = 8'h00;
      step();
      if (state_o !== 3'd3 || eval_now_o !== 1'b0 || timeout_o !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL to_wait_hold got bad%0d want 0", bad); end
    step();
    checks++;
    if (state_o !== 3'd2 || timeout_o !== 1'b1 || user_guess_o !== 3'd0) begin
      errors++;
      $display("FAIL to_fire got s%0d t%0d g%0d want s2 t1 g0", state_o, timeout_o, user_guess_o);
    end
    step();
    checks++;
    if (timeout_o !== 1'b0 || eval_now_o !== 1'b0 || state_o !== 3'd2) begin
      errors++;
      $display("FAIL to_once got s%0d t%0d e%0d want s2 t0 e0", state_o, timeout_o, eval_now_o);
    end
  endtask

`ifdef WHACK_PENALTY_EN
  task automatic test_penalty();
    int bad;
    btn_i = 8'h10;
    step();
    btn_i = 8'h00;
    guess_wrong_i = 1'b1;
    step();
    guess_wrong_i = 1'b0;
    checks++;
    if (state_o !== 3'd5) begin errors++; $display("FAIL pen_enter got %0d want 5", state_o); end
    bad = 0;
    btn_i = 8'h02;
    step();
    btn_i = 8'h00;
    if (state_o !== 3'd5 || eval_now_o !== 1'b0) bad++;
    for (int i = 0; i < 2; i++) begin
      step();
      if (state_o !== 3'd5 || eval_now_o !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL pen_lockout got bad%0d want 0", bad); end
    step();
    checks++;
    if (state_o !== 3'd2 || eval_now_o !== 1'b0) begin
      errors++; $display("FAIL pen_exit got s%0d e%0d want s2 e0", state_o, eval_now_o);
    end
    btn_i = 8'h01;
    step();
    btn_i = 8'h00;
    guess_wrong_i = 1'b1;
    step();
    guess_wrong_i = 1'b0;
    game_over_i = 1'b1;
    step();
    game_over_i = 1'b0;
    checks++;
    if (state_o !== 3'd4) begin errors++; $display("FAIL pen_gameover got %0d want 4", state_o); end
  endtask
`endif

  task automatic play_to_over(input logic [7:0] score);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    score_i = score;
    game_over_i = 1'b1;
    step();
    game_over_i = 1'b0;
    step();
  endtask

  task automatic test_high_score();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    play_to_over(8'd7);
    checks++;
    if (state_o !== 3'd4 || high_score_o !== 8'd7) begin
      errors++; $display("FAIL hs_first got s%0d h%0d want s4 h7", state_o, high_score_o);
    end
    play_to_over(8'd5);
    checks++;
    if (high_score_o !== 8'd7) begin errors++; $display("FAIL hs_lower got %0d want 7", high_score_o); end
    play_to_over(8'd7);
    checks++;
    if (high_score_o !== 8'd7) begin errors++; $display("FAIL hs_equal got %0d want 7", high_score_o); end
    play_to_over(8'd9);
    checks++;
    if (high_score_o !== 8'd9) begin errors++; $display("FAIL hs_higher got %0d want 9", high_score_o); end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    checks++;
    if (high_score_o !== 8'd0 || state_o !== 3'd0) begin
      errors++; $display("FAIL hs_rst got h%0d s%0d want h0 s0", high_score_o, state_o);
    end
  endtask

  // Model of the game rules: which phase of play we are in and what the player has done.
  int         m_phase;
  int         m_wait;
  int         m_pen;
  logic [2:0] m_guess;
  logic       m_eval, m_to;
  logic [7:0] m_hs, m_pbtn;
  logic       m_pstart;

  task automatic model_reset();
    m_phase = 0; m_wait = 0; m_pen = 0; m_guess = 0; m_eval = 0; m_to = 0;
    m_hs = 0; m_pbtn = 0; m_pstart = 0;
  endtask

  task automatic model_step();
    logic [7:0] press;
    logic       sp;
    bit         found;
    press = btn_i & ~m_pbtn;
    sp = start_i && !m_pstart;
    m_pbtn = btn_i;
    m_pstart = start_i;
    m_eval = 0;
    m_to = 0;
    if (m_phase == 0 || m_phase == 4) begin
      if (sp) m_phase = 1;
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (sp) begin
      m_phase = 1;
    end else if (game_over_i) begin
      m_phase = 4;
      if (score_i > m_hs) m_hs = score_i;
    end else if (m_phase == 2) begin
      found = 0;
      for (int k = 0; k < 8; k++) begin
        if (press[k] && !found) begin found = 1; m_guess = 3'(k); end
      end
      if (found) begin m_eval = 1; m_phase = 3; m_wait = 0; end
    end else if (m_phase == 3) begin
      if (guess_correct_i) m_phase = 2;
      else if (guess_wrong_i) begin
`ifdef WHACK_PENALTY_EN
        m_phase = 5; m_pen = 0;
`else
        m_phase = 2;
`endif
      end else begin
        m_wait++;
        if (m_wait >= int'(ResTo)) begin m_phase = 2; m_to = 1; end
      end
    end else begin
      m_pen++;
      if (m_pen >= int'(PenCy)) m_phase = 2;
    end
  endtask

  task automatic test_random();
    int bad;
    rst_i = 1'b1;
    btn_i = 0; start_i = 0; guess_correct_i = 0; guess_wrong_i = 0; game_over_i = 0;
    step();
    model_reset();
    rst_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      rst_i = ($urandom % 500 == 0);
      if ($urandom % 4 == 0) btn_i = ($urandom % 2) ? 8'($urandom) : 8'(1 << ($urandom % 8));
      start_i = ($urandom % 50 == 0);
      guess_correct_i = ($urandom % 7 == 0);
      guess_wrong_i = ($urandom % 7 == 0);
      game_over_i = ($urandom % 90 == 0);
      score_i = 8'($urandom);
      if (rst_i) model_reset();
      else model_step();
      step();
      checks++;
      if (state_o !== 3'(m_phase) || eval_now_o !== m_eval || timeout_o !== m_to ||
          user_guess_o !== m_guess || high_score_o !== m_hs ||
          restart_game_o !== (m_phase == 1)) begin
        errors++;
        if (bad < 10)
          $display("FAIL random_cycle%0d got s%0d e%0d t%0d g%0d h%0d r%0d want s%0d e%0d t%0d g%0d h%0d r%0d",
                   i, state_o, eval_now_o, timeout_o, user_guess_o, high_score_o, restart_game_o,
                   m_phase, m_eval, m_to, m_guess, m_hs, (m_phase == 1));
        bad++;
      end
    end
    rst_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start();
    test_guess();
    test_multi_hold();
    test_timeout();
`ifdef WHACK_PENALTY_EN
    test_penalty();
`endif
    test_high_score();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
